router_out_queue: RTL and testbench

- Downstream stage of the 8-bit address router.
- Takes each routed address plus the router's 2-bit port decision and a hit flag, and enqueues the address into one of four per-port FIFOs.
- Each output port drains independently over its own valid/ready handshake.
- Addresses that miss the routing table are dropped and counted.

---
 rtl/router_q_pkg.sv | 11 +
 rtl/router_fifo.sv | 61 ++++++
 rtl/router_out_queue.sv | 83 ++++++++
 tb/tb_router_out_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_q_pkg.sv
// rtl/router_q_pkg.sv - shared widths and types for the router output queue
package router_q_pkg;

    localparam int NPORTS = 4;
    localparam int PORT_W = 2;
    localparam int ADDR_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PORT_W-1:0] port_t;

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - single-clock per-port address FIFO
// Head data reads as zero while the FIFO is empty.
module router_fifo
    import router_q_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          wdata,
    output logic [ADDR_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    addr_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full FIFO is refused even if the head pops this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/router_out_queue.sv
// rtl/router_out_queue.sv - per-port output queues behind the address router
// ROUTER_Q_DROP_FULL_EN: hits to a full port are dropped and counted instead of stalling.
module router_out_queue
    import router_q_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [PORT_W-1:0]          in_port,
    input  logic                       in_hit,
    output logic [NPORTS-1:0]          out_valid,
    input  logic [NPORTS-1:0]          out_ready,
    output logic [NPORTS*ADDR_W-1:0]   out_addr,
    output logic [NPORTS-1:0]          full,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] empty;
    logic [CNT_W-1:0]  count [NPORTS];
    logic              accept;
    logic              port_full;
    logic              drop_ev;

    assign port_full = full[in_port];
    assign accept    = in_valid & in_ready;

    always_comb begin
        in_ready = 1'b0;
        drop_ev  = 1'b0;
`ifdef ROUTER_Q_DROP_FULL_EN
        in_ready = reset;
        drop_ev  = accept & (~in_hit | port_full);
`else
        in_ready = reset & (~in_hit | ~port_full);
        drop_ev  = accept & ~in_hit;
`endif
    end

    always_comb begin
        push = '0;
        for (int i = 0; i < NPORTS; i++) begin
            push[i] = accept & in_hit & (in_port == PORT_W'(i));
        end
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        assign pop[i]       = out_ready[i] & ~empty[i];
        assign out_valid[i] = (count[i] != '0);

        router_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (in_addr),
            .rdata (out_addr[i*ADDR_W +: ADDR_W]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
        );
    end

    // Saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop_ev && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_router_out_queue.sv
// tb/tb_router_out_queue.sv - directed and randomized bench for router_out_queue
module tb_router_out_queue;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 2;
    localparam int DMAX   = (1 << DROP_W) - 1;
`ifdef ROUTER_Q_DROP_FULL_EN
    localparam bit DROP_FULL = 1'b1;
`else
    localparam bit DROP_FULL = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_addr;
    logic [1:0]        in_port;
    logic              in_hit;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [31:0]       out_addr;
    logic [3:0]        full;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] q [4][$];
    int         drops;

    router_out_queue #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_port   (in_port),
        .in_hit    (in_hit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .full      (full),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input logic h, input logic [1:0] p);
        if (!h) return 1'b1;
        return DROP_FULL || (q[p].size() < DEPTH);
    endfunction

    task automatic check_model();
        logic [3:0]  ev;
        logic [3:0]  ef;
        logic [31:0] ea;
        ev = '0;
        ef = '0;
        ea = '0;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                ev[i] = 1'b1;
                ea[i*8 +: 8] = q[i][0];
            end
            ef[i] = (q[i].size() == DEPTH);
        end
        chk("in_ready", in_ready, model_ready(in_hit, in_port));
        chk("out_valid", out_valid, ev);
        chk("out_addr", out_addr, ea);
        chk("full", full, ef);
        chk("drop_cnt", drop_cnt, drops);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) q[i].delete();
        drops = 0;
    endtask

    // One clock: drive, compare at negedge, advance the model at posedge.
    task automatic cyc(input logic v, input logic [7:0] a, input logic [1:0] p,
                       input logic h, input logic [3:0] ordy);
        bit acc;
        bit do_push;
        in_valid  = v;
        in_addr   = a;
        in_port   = p;
        in_hit    = h;
        out_ready = ordy;
        @(negedge clk);
        check_model();
        @(posedge clk);
        acc     = v && model_ready(h, p);
        do_push = acc && h && (q[p].size() < DEPTH);
        for (int i = 0; i < 4; i++) begin
            if (ordy[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (do_push) q[p].push_back(a);
        if (acc && !do_push && drops < DMAX) drops++;
        #1;
    endtask

    logic [7:0] seq [4];

    initial begin
        in_valid  = 1'b0;
        in_addr   = '0;
        in_port   = '0;
        in_hit    = 1'b0;
        out_ready = '0;
        reset     = 1'b1;
        clear_model();
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_full", full, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic routing
        cyc(1, 8'hDB, 2'd3, 1, 4'hF);
        chk("basic_valid3", out_valid, 4'b1000);
        chk("basic_addr3", out_addr[31:24], 8'hDB);
        cyc(1, 8'hC6, 2'd2, 1, 4'hF);
        chk("basic_valid2", out_valid, 4'b0100);
        chk("basic_addr2", out_addr[23:16], 8'hC6);
        cyc(0, 8'h00, 2'd0, 0, 4'hF);
        chk("basic_popped", out_valid, 4'b0000);

        // Miss
        cyc(1, 8'h77, 2'd1, 0, 4'hF);
        chk("miss_drop", drop_cnt, 1);
        chk("miss_valid", out_valid, 0);
        chk("miss_ready", in_ready, 1);

        // Full / backpressure on port 1
        seq[0] = 8'hF9; seq[1] = 8'h29; seq[2] = 8'h11; seq[3] = 8'h22;
        for (int k = 0; k < 4; k++) cyc(1, seq[k], 2'd1, 1, 4'hD);
        chk("bp_full", full, 4'b0010);
        in_valid = 1'b1; in_addr = 8'h33; in_port = 2'd1; in_hit = 1'b1;
        #1;
        chk("bp_in_ready", in_ready, DROP_FULL);
        cyc(1, 8'h33, 2'd1, 1, 4'hD);
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain", out_addr[15:8], seq[k]);
            cyc(0, 8'h00, 2'd0, 0, 4'hF);
        end
        chk("bp_empty", out_valid, 0);

        // Push + pop on the same port
        cyc(1, 8'hA1, 2'd0, 1, 4'hE);
        cyc(1, 8'hA2, 2'd0, 1, 4'hE);
        cyc(1, 8'hDC, 2'd0, 1, 4'hF);
        chk("pp_head", out_addr[7:0], 8'hA2);
        cyc(0, 8'h00, 2'd0, 0, 4'hF);
        chk("pp_next", out_addr[7:0], 8'hDC);
        cyc(0, 8'h00, 2'd0, 0, 4'hF);

        // Reset mid-traffic
        cyc(1, 8'h11, 2'd0, 1, 4'h0);
        cyc(1, 8'h22, 2'd2, 1, 4'h0);
        cyc(1, 8'h33, 2'd3, 1, 4'h0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_addr", out_addr, 0);
        reset = 1'b1;
        clear_model();
        cyc(1, 8'h44, 2'd1, 1, 4'hE);
        chk("post_rst_valid", out_valid, 4'b0010);
        chk("post_rst_addr", out_addr[15:8], 8'h44);
        cyc(0, 8'h00, 2'd0, 0, 4'hF);

`ifdef ROUTER_Q_DROP_FULL_EN
        for (int k = 0; k < 4; k++) cyc(1, seq[k], 2'd1, 1, 4'h0);
        cyc(1, 8'h55, 2'd1, 1, 4'h0);
        chk("dfull_drop", drop_cnt, 1);
        chk("dfull_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) cyc(0, 8'h00, 2'd0, 0, 4'hF);
`endif

        // Saturation
        for (int k = 0; k < 5; k++) cyc(1, 8'h77, 2'd0, 0, 4'hF);
        chk("sat_drop", drop_cnt, DMAX);
        cyc(0, 8'h00, 2'd0, 0, 4'hF);
        chk("sat_hold", drop_cnt, DMAX);

        // Randomized traffic against the queue model
        reset = 1'b0;
        #1 reset = 1'b1;
        clear_model();
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 4) != 0, 8'($urandom), 2'($urandom), ($urandom % 5) != 0,
                4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
